servo_frame_decoder: RTL and testbench
======================================

// Module: servo_frame_decoder
// PURPOSE
//  Decodes the UART receive byte stream into NUM_CH servo PWM compare values.
//  Each value is carried as a high byte followed by a low byte.
//  Adds the following:
//   - channel addressing, synchronous operation and a pair timeout.
//   - range clamping, optional all-channel synchronous update, error counter.
//  Sits between the UART receiver and the per-servo PWM generators.
// PARAMETERS
//  NUM_CH       2     servo channels, 1..4 (channel id is 2 bits on the wire)
//  MIN_VAL      10'd0    lower clamp applied to decoded value
//  MAX_VAL      10'd1023 upper clamp applied to decoded value
//  RESET_VAL    10'd512  per-channel output value after reset
//  TIMEOUT_CYC  50000 clocks allowed between high and low byte of a pair
//  SYNC_MODE    0     0: update each channel on its commit; 1: update all together
// PORTS
//  clk         in   1          system clock
//  reset_n     in   1          asynchronous active-low reset
//  rx_data     in   8          received byte, valid when rx_valid=1
//  rx_valid    in   1          one-cycle strobe from UART receiver
//  pwm_val     out  NUM_CH*10  channel c at bits [c*10+9 : c*10]
//  update      out  1          one-cycle pulse when pwm_val changes
//  err_count   out  8          saturating count of protocol errors
// BEHAVIOUR
//  Byte format: [7]=half (1 = high, 0 = low), [6:5]=channel, [4:0]=payload.
//   value = {high_payload, low_payload}, 10 bits unsigned.
//  Reset (async, reset_n=0):
//   - every pwm_val channel = RESET_VAL; shadow regs = RESET_VAL.
//   - update=0, err_count=0, FSM=IDLE, timer=0.
//   - a pair in progress is discarded.
//  FSM (all decisions on a clk edge with rx_valid=1):
//   IDLE, high byte, ch<NUM_CH:
//    - store payload and ch; go to WAIT_LOW; timer=0.
//   IDLE, low byte:
//    - error (orphan low); stay in IDLE.
//   Any state, ch>=NUM_CH:
//    - error; byte dropped; go to IDLE.
//   WAIT_LOW, low byte, same ch:
//    - commit; go to IDLE.
//   WAIT_LOW, low byte, other ch:
//    - error; go to IDLE; nothing committed.
//   WAIT_LOW, high byte, valid ch:
//    - error; new high byte replaces the stored one; stay in WAIT_LOW; timer=0.
//   WAIT_LOW, no rx_valid:
//    - timer increments.
//    - when timer reaches TIMEOUT_CYC-1: error; go to IDLE.
//   rx_valid and timeout expiry in the same cycle:
//    - the byte is processed; the timeout is ignored.
//  Commit:
//   - v = min(max(value, MIN_VAL), MAX_VAL); shadow[ch] = v on the same edge.
//   - SYNC_MODE=0: pwm_val[ch] = v on the same edge; update=1 for the next cycle.
//   - SYNC_MODE=1: pwm_val is loaded from all shadows only on a commit to
//     channel NUM_CH-1 (latest value included); update pulses then only.
//  Latency:
//   - pwm_val and update are visible 1 clk after the low-byte rx_valid cycle.
//   - update is high for exactly 1 cycle; back-to-back commits give
//     back-to-back pulses.
//  err_count:
//   - +1 per error event; saturates at 255.
//   - never wraps; cleared only by reset.
//  rx_valid held high for multiple cycles: each cycle counts as a new byte.
// TESTING
//  T1 reset:
//   assert reset_n=0 mid-pair -> all channels=512, update=0, err_count=0.
//   then send lone low byte 8'h05 -> err_count=1.
//  T2 basic:
//   SYNC_MODE=0, send 8'h90 then 8'h05 (ch0 high=16, low=5)
//   -> pwm_val[9:0]=10'd517 one clk later, update=1 for one cycle,
//      ch1 unchanged at 512.
//  T3 clamp:
//   MIN_VAL=100, MAX_VAL=900, send ch1 pair 8'hBF,8'h3F (1023) -> ch1=900.
//   send ch1 pair 8'hA0,8'h20 (0) -> ch1=100.
//  T4 errors:
//   send 8'h90 then 8'h25 (low byte, ch1) -> no commit, err_count=1.
//   send 8'hE0 with NUM_CH=2 (ch3) -> err_count=2.
//   send two high bytes for ch0, then low -> commit uses second high, err_count=3.
//  T5 timeout:
//   TIMEOUT_CYC=20, send 8'h90 then idle for 20 clks, then 8'h05
//   -> no commit, err_count=2 (timeout + orphan low).
//   repeat with the low byte on clk 19 -> commit 517.
//  T6 sync mode:
//   SYNC_MODE=1, NUM_CH=2, commit ch0=300 -> pwm_val unchanged, update=0.
//   commit ch1=700 -> ch0=300 and ch1=700 appear on the same edge, single update.

Source files
------------

// File: rtl/servo_frame_decoder_if.sv
// Byte stream from the UART receiver into the servo frame decoder.
// The receiver drives the master side and the decoder consumes the slave side.
interface servo_frame_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/servo_frame_decoder.sv
// Turns high/low byte pairs from the UART into clamped 10-bit servo compare values.
// It keeps an error counter and can optionally update all channels together.
module servo_frame_decoder #(
  parameter int             NUM_CH      = 2,
  parameter logic [9:0]     MIN_VAL     = 10'd0,
  parameter logic [9:0]     MAX_VAL     = 10'd1023,
  parameter logic [9:0]     RESET_VAL   = 10'd512,
  parameter int             TIMEOUT_CYC = 50000,
  parameter bit             SYNC_MODE   = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  servo_frame_decoder_if.slave     rx,
  output logic [NUM_CH*10-1:0]     pwm_val,
  output logic                     update,
  output logic [7:0]               err_count
);

  localparam int         TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0] NUM_CH_W = 3'(NUM_CH);

  typedef enum logic {IDLE, WAIT_LOW} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    hi_q, hi_d;
  logic [1:0]    ch_q, ch_d;
  logic [9:0]    shadow_q [NUM_CH];
  logic [9:0]    shadow_d [NUM_CH];
  logic [9:0]    pwm_q    [NUM_CH];
  logic [9:0]    pwm_d    [NUM_CH];
  logic          update_q, update_d;
  logic [7:0]    err_q, err_d;

  logic          rx_half;
  logic [1:0]    rx_ch;
  logic [4:0]    rx_pay;
  logic          ch_ok;
  logic          err_evt;
  logic          commit;
  logic [9:0]    value_c;

  function automatic logic [9:0] clamp10(input logic [9:0] x);
    if (x <= MIN_VAL)      return MIN_VAL;
    else if (x >= MAX_VAL) return MAX_VAL;
    else                   return x;
  endfunction

  assign rx_half = rx.rx_data[7];
  assign rx_ch   = rx.rx_data[6:5];
  assign rx_pay  = rx.rx_data[4:0];
  assign ch_ok   = ({1'b0, rx_ch} < NUM_CH_W);
  assign value_c = clamp10({hi_q, rx_pay});

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    hi_d     = hi_q;
    ch_d     = ch_q;
    shadow_d = shadow_q;
    pwm_d    = pwm_q;
    update_d = 1'b0;
    err_evt  = 1'b0;
    commit   = 1'b0;

    // An arriving byte always wins over a timeout expiring on the same edge.
    if (rx.rx_valid) begin
      if (!ch_ok) begin
        err_evt = 1'b1;
        state_d = IDLE;
      end else if (rx_half) begin
        err_evt = (state_q == WAIT_LOW);
        hi_d    = rx_pay;
        ch_d    = rx_ch;
        state_d = WAIT_LOW;
        timer_d = '0;
      end else begin
        if (state_q == WAIT_LOW && rx_ch == ch_q) commit  = 1'b1;
        else                                      err_evt = 1'b1;
        state_d = IDLE;
      end
    end else if (state_q == WAIT_LOW) begin
      if (timer_q == TMR_LAST) begin
        err_evt = 1'b1;
        state_d = IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    if (commit) begin
      for (int c = 0; c < NUM_CH; c++)
        if (ch_q == 2'(c)) shadow_d[c] = value_c;
      if (!SYNC_MODE) begin
        for (int c = 0; c < NUM_CH; c++)
          if (ch_q == 2'(c)) pwm_d[c] = value_c;
        update_d = 1'b1;
      end else if ({1'b0, ch_q} == NUM_CH_W - 3'd1) begin
        pwm_d    = shadow_d;
        update_d = 1'b1;
      end
    end

    err_d = (err_evt && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      hi_q     <= '0;
      ch_q     <= '0;
      update_q <= 1'b0;
      err_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        shadow_q[c] <= RESET_VAL;
        pwm_q[c]    <= RESET_VAL;
      end
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      hi_q     <= hi_d;
      ch_q     <= ch_d;
      update_q <= update_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  always_comb begin
    pwm_val = '0;
    for (int c = 0; c < NUM_CH; c++) pwm_val[c*10 +: 10] = pwm_q[c];
  end

  assign update    = update_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_servo_frame_decoder.sv
// Directed bench for servo_frame_decoder: one per-channel instance and one
// synchronous-update instance share a single receive byte stream.
module tb_servo_frame_decoder;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  servo_frame_decoder_if rx ();

  logic [19:0] pa_val, pb_val;
  logic        pa_upd, pb_upd;
  logic [7:0]  pa_err, pb_err;

  servo_frame_decoder #(
    .NUM_CH(2), .MIN_VAL(10'd100), .MAX_VAL(10'd900), .RESET_VAL(10'd512),
    .TIMEOUT_CYC(20), .SYNC_MODE(1'b0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .rx(rx),
    .pwm_val(pa_val), .update(pa_upd), .err_count(pa_err)
  );

  servo_frame_decoder #(
    .NUM_CH(2), .MIN_VAL(10'd0), .MAX_VAL(10'd1023), .RESET_VAL(10'd512),
    .TIMEOUT_CYC(20), .SYNC_MODE(1'b1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .rx(rx),
    .pwm_val(pb_val), .update(pb_upd), .err_count(pb_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called on a falling edge; the byte is taken on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx.rx_data  = b;
    rx.rx_valid = 1'b1;
    @(negedge clk);
    rx.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    rx.rx_valid = 1'b0;
    rx.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // T1: reset mid-pair
    send_byte(8'h88); send_byte(8'h05);
    chk("pre_commit_ch0", pa_val[9:0], 261);
    send_byte(8'h90);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ch0", pa_val[9:0], 512);
    chk("rst_ch1", pa_val[19:10], 512);
    chk("rst_update", pa_upd, 0);
    chk("rst_err", pa_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    send_byte(8'h05);
    chk("orphan_low_err", pa_err, 1);
    chk("orphan_low_ch0", pa_val[9:0], 512);

    // T2: basic commit on ch0
    do_reset();
    send_byte(8'h90); send_byte(8'h05);
    chk("basic_ch0", pa_val[9:0], 517);
    chk("basic_update", pa_upd, 1);
    chk("basic_ch1", pa_val[19:10], 512);
    idle(1);
    chk("basic_update_off", pa_upd, 0);

    // T3: clamp on ch1
    send_byte(8'hBF); send_byte(8'h3F);
    chk("clamp_hi_ch1", pa_val[19:10], 900);
    chk("clamp_hi_update", pa_upd, 1);
    send_byte(8'hA0); send_byte(8'h20);
    chk("clamp_lo_ch1", pa_val[19:10], 100);
    chk("clamp_ch0_kept", pa_val[9:0], 517);

    // T4: protocol errors
    do_reset();
    send_byte(8'h90); send_byte(8'h25);
    chk("wrong_ch_err", pa_err, 1);
    chk("wrong_ch_nocommit", pa_val[9:0], 512);
    chk("wrong_ch_noupd", pa_upd, 0);
    send_byte(8'hE0);
    chk("bad_ch_err", pa_err, 2);
    send_byte(8'h90); send_byte(8'h88); send_byte(8'h05);
    chk("double_high_ch0", pa_val[9:0], 261);
    chk("double_high_err", pa_err, 3);

    // T5: pair timeout
    do_reset();
    send_byte(8'h90); idle(20); send_byte(8'h05);
    chk("timeout_err", pa_err, 2);
    chk("timeout_nocommit", pa_val[9:0], 512);
    send_byte(8'h90); idle(18); send_byte(8'h05);
    chk("in_time_ch0", pa_val[9:0], 517);
    chk("in_time_err", pa_err, 2);

    // T6: synchronous update
    do_reset();
    send_byte(8'h89); send_byte(8'h0C);
    chk("sync_ch0_held", pb_val[9:0], 512);
    chk("sync_ch1_held", pb_val[19:10], 512);
    chk("sync_no_update", pb_upd, 0);
    send_byte(8'hB5); send_byte(8'h3C);
    chk("sync_ch0", pb_val[9:0], 300);
    chk("sync_ch1", pb_val[19:10], 700);
    chk("sync_update", pb_upd, 1);
    idle(1);
    chk("sync_update_off", pb_upd, 0);
    chk("sync_err", pb_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
